metronome_tempo_ctrl: RTL and testbench

Tempo controller for the bonus metronome. It holds the current BPM setting and drives bpm_o directly into the three-digit seven-segment display stage. It changes the setting from increment/decrement buttons, with auto-repeat while a button is held. While running, it emits beat pulses at exactly the set tempo, with a downbeat accent every bar.

---
 rtl/metronome_pkg.sv | 24 ++
 rtl/metronome_tempo_ctrl_button_repeat.sv | 67 ++++++
 rtl/metronome_tempo_ctrl.sv | 134 +++++++++++++
 tb/tb_metronome_tempo_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/metronome_pkg.sv
// Shared constants for the metronome tempo controller: display width,
// button FSM encoding and accumulator sizing helpers.
package metronome_pkg;

  // Tempo register width, sized for a three-digit display.
  localparam int BPM_W = 10;

  // Button hold/repeat FSM encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Beat threshold: one beat per minute's worth of clock cycles per BPM.
  function automatic longint thresh_of(input longint clk_hz);
    return 60 * clk_hz;
  endfunction

  // Accumulator holds acc < THRESH; acc + bpm must also fit, so leave
  // headroom for the largest displayable tempo.
  function automatic int acc_width(input longint clk_hz);
    return $clog2(thresh_of(clk_hz) + 64'd1024);
  endfunction

endpackage

// File: rtl/metronome_tempo_ctrl_button_repeat.sv
// Button conditioner: rising-edge step plus hold-then-auto-repeat steps.
// step_o is combinational so the tempo register updates on the same edge
// that samples the button rise.
module button_repeat
  import metronome_pkg::*;
#(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic step_o
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             prev;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             rise;
  logic             hold_done;
  logic             rep_done;

  assign rise      = in_i & ~prev;
  assign hold_done = in_i && (state == ST_HOLD)   && (cnt == HOLD_LAST);
  assign rep_done  = in_i && (state == ST_REPEAT) && (cnt == REP_LAST);
  assign step_o    = ((state == ST_IDLE) && rise) || hold_done || rep_done;

  // Edge history, hold/repeat state and cycle counter; release drops to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev  <= 1'b0;
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      prev <= in_i;
      if (!in_i) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: if (rise) begin
            state <= ST_HOLD;
            cnt   <= '0;
          end
          ST_HOLD: if (hold_done) begin
            state <= ST_REPEAT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
          ST_REPEAT: if (rep_done) cnt <= '0;
                     else          cnt <= cnt + 1'b1;
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/metronome_tempo_ctrl.sv
// Metronome tempo controller: saturating BPM setting from inc/dec buttons
// with auto-repeat, run/stop toggle, and a divider-free phase accumulator
// that emits beats at the exact average tempo with a per-bar accent.
module metronome_tempo_ctrl
  import metronome_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int BPM_MIN       = 30,
  parameter int BPM_MAX       = 300,
  parameter int BPM_DEFAULT   = 120,
  parameter int BEATS_PER_BAR = 4,
  parameter int HOLD_CYCLES   = CLK_HZ / 2,
  parameter int REPEAT_CYCLES = CLK_HZ / 10,
  parameter int LED_CYCLES    = CLK_HZ / 20
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             inc_i,
  input  logic                             dec_i,
  input  logic                             run_i,
  output logic [BPM_W-1:0]                 bpm_o,
  output logic                             running_o,
  output logic                             beat_o,
  output logic                             accent_o,
  output logic [$clog2(BEATS_PER_BAR)-1:0] beat_idx_o,
  output logic                             led_o
);

  localparam int                ACC_W  = acc_width(CLK_HZ);
  localparam logic [ACC_W-1:0]  THRESH = ACC_W'(thresh_of(CLK_HZ));
  localparam int                IDX_W  = $clog2(BEATS_PER_BAR);
  localparam int                LED_W  = $clog2(LED_CYCLES + 1);

  logic             inc_step;
  logic             dec_step;
  logic             run_prev;
  logic             run_rise;
  logic [BPM_W-1:0] bpm;
  logic             running;
  logic             start_pend;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic             acc_wrap;
  logic             beat_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic             beat;
  logic             accent;
  logic [LED_W-1:0] led_cnt;

  button_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_inc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .in_i  (inc_i),
    .step_o(inc_step)
  );

  button_repeat #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dec (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .in_i  (dec_i),
    .step_o(dec_step)
  );

  assign run_rise = run_i & ~run_prev;
  assign acc_sum  = acc + ACC_W'(bpm);
  assign acc_wrap = acc_sum >= THRESH;
  assign idx_next = (idx == IDX_W'(BEATS_PER_BAR - 1)) ? '0 : idx + 1'b1;
  // A run toggle on this edge suppresses any beat; otherwise either the
  // pending downbeat or an accumulator wrap produces one.
  assign beat_next = !run_rise && (start_pend || (running && acc_wrap));

  // Tempo setting: single steps saturate; opposing steps cancel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bpm <= BPM_W'(BPM_DEFAULT);
    end else if (inc_step && !dec_step && (bpm < BPM_W'(BPM_MAX))) begin
      bpm <= bpm + 1'b1;
    end else if (dec_step && !inc_step && (bpm > BPM_W'(BPM_MIN))) begin
      bpm <= bpm - 1'b1;
    end
  end

  // Run toggle, downbeat on start, and the phase accumulator beat engine.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_prev   <= 1'b0;
      running    <= 1'b0;
      start_pend <= 1'b0;
      acc        <= '0;
      idx        <= '0;
      beat       <= 1'b0;
      accent     <= 1'b0;
    end else begin
      run_prev <= run_i;
      beat     <= beat_next;
      accent   <= 1'b0;
      if (run_rise) begin
        running    <= ~running;
        start_pend <= ~running;
        acc        <= '0;
        idx        <= '0;
      end else if (start_pend) begin
        start_pend <= 1'b0;
        acc        <= '0;
        idx        <= '0;
        accent     <= 1'b1;
      end else if (running) begin
        if (acc_wrap) begin
          acc    <= acc_sum - THRESH;
          idx    <= idx_next;
          accent <= (idx_next == '0);
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  // LED stretch: each beat reloads the counter; LED is lit while nonzero.
  always_ff @(posedge clk_i) begin
    if (rst_i)               led_cnt <= '0;
    else if (beat_next)      led_cnt <= LED_W'(LED_CYCLES);
    else if (led_cnt != '0)  led_cnt <= led_cnt - 1'b1;
  end

  assign bpm_o      = bpm;
  assign running_o  = running;
  assign beat_o     = beat;
  assign accent_o   = accent;
  assign beat_idx_o = idx;
  assign led_o      = (led_cnt != '0);

endmodule

// File: tb/tb_metronome_tempo_ctrl.sv
// Self-checking bench for metronome_tempo_ctrl. A reference model keyed on
// press durations and cumulative tempo sums predicts every output; beats
// are queued as expected events and popped by a separate monitor.
module tb_metronome_tempo_ctrl;

  localparam int CLK_HZ = 100;
  localparam int TH     = 6000;
  localparam int HOLD   = 20;
  localparam int REP    = 5;
  localparam int LEDC   = 3;
  localparam int BPB    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       run = 1'b0;
  logic [9:0] bpm_o;
  logic       running_o, beat_o, accent_o, led_o;
  logic [1:0] beat_idx_o;

  always #5 clk = ~clk;

  metronome_tempo_ctrl #(
    .CLK_HZ(CLK_HZ), .BPM_MIN(30), .BPM_MAX(300), .BPM_DEFAULT(120),
    .BEATS_PER_BAR(BPB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .LED_CYCLES(LEDC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .inc_i(inc), .dec_i(dec), .run_i(run),
    .bpm_o(bpm_o), .running_o(running_o), .beat_o(beat_o), .accent_o(accent_o),
    .beat_idx_o(beat_idx_o), .led_o(led_o)
  );

  int total = 0;
  int bad   = 0;
  longint cyc = 0;

  typedef struct { longint c; int idx; bit acc; } beat_t;
  beat_t exp_q[$];
  beat_t e;

  // Reference model state
  int     m_bpm = 120;
  bit     m_run = 0, m_pend = 0;
  int     m_idx = 0;
  longint m_cum = 0, m_nb = 0;
  int     m_led = 0;
  bit     p_inc = 0, p_dec = 0, p_run = 0;
  int     d_inc = -1, d_dec = -1;
  int     old_bpm;
  bit     st_i, st_d, bt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
    end
  endtask

  // Press-duration rule: step on the press, after HOLD cycles, then every REP.
  function automatic bit step_at(input int d);
    return (d == 0) || (d == HOLD) || ((d > HOLD) && ((d - HOLD) % REP == 0));
  endfunction

  // Model: state after each rising edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_bpm = 120; m_run = 0; m_pend = 0; m_idx = 0; m_cum = 0; m_nb = 0; m_led = 0;
      p_inc = 0; p_dec = 0; p_run = 0; d_inc = -1; d_dec = -1;
      exp_q.delete();
    end else begin
      if (!inc) d_inc = -1; else if (!p_inc) d_inc = 0; else if (d_inc >= 0) d_inc++;
      if (!dec) d_dec = -1; else if (!p_dec) d_dec = 0; else if (d_dec >= 0) d_dec++;
      st_i = inc && (d_inc >= 0) && step_at(d_inc);
      st_d = dec && (d_dec >= 0) && step_at(d_dec);
      old_bpm = m_bpm;
      if (st_i && !st_d && m_bpm < 300) m_bpm++;
      else if (st_d && !st_i && m_bpm > 30) m_bpm--;
      bt = 0;
      if (run && !p_run) begin
        if (m_run) begin m_run = 0; m_pend = 0; m_idx = 0; end
        else begin m_run = 1; m_pend = 1; end
      end else if (m_pend) begin
        m_pend = 0; m_idx = 0; m_cum = 0; m_nb = 1; bt = 1;
      end else if (m_run) begin
        m_cum += old_bpm;
        if (m_cum >= m_nb * TH) begin m_nb++; m_idx = (m_idx + 1) % BPB; bt = 1; end
      end
      if (bt) begin
        exp_q.push_back('{c: cyc, idx: m_idx, acc: (m_idx == 0)});
        m_led = LEDC;
      end else if (m_led > 0) begin
        m_led--;
      end
      p_inc = inc; p_dec = dec; p_run = run;
    end
  end

  // Monitor: compare each cycle on the falling edge; pop beats as they appear.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("bpm", bpm_o, m_bpm);
      chk("running", running_o, m_run);
      chk("led", led_o, m_led > 0);
      chk("beat_idx", beat_idx_o, m_idx);
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        e = exp_q.pop_front();
        chk("beat", beat_o, 1);
        chk("accent", accent_o, e.acc);
        chk("beat_idx_at_beat", beat_idx_o, e.idx);
      end else begin
        chk("beat", beat_o, 0);
        chk("accent", accent_o, 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_run();
    run = 1; tick(2); run = 0; tick(1);
  endtask

  initial begin
    rst = 1; tick(3); rst = 0; tick(2);
    #2 chk("rst_bpm", bpm_o, 120); chk("rst_running", running_o, 0);

    // Run at 120: beats every 50 cycles, accent every 4th
    press_run(); tick(220);

    // Hold dec 161 cycles: 30 steps -> 90 while running
    dec = 1; tick(161); dec = 0; tick(1);
    #2 chk("bpm_90", bpm_o, 90);
    tick(420);

    // Stop mid-bar
    press_run(); tick(30);
    #2 chk("stop_idx", beat_idx_o, 0); chk("stop_running", running_o, 0);

    // Hold inc 36 cycles from 120 -> 125
    rst = 1; tick(2); rst = 0; tick(2);
    inc = 1; tick(36); inc = 0; tick(2);
    #2 chk("hold_inc", bpm_o, 125);

    // Saturate at max, then extra inc is a no-op
    inc = 1; tick(1000); inc = 0; tick(2);
    #2 chk("sat_max", bpm_o, 300);
    inc = 1; tick(3); inc = 0; tick(2);
    #2 chk("sat_inc", bpm_o, 300);
    inc = 1; dec = 1; tick(3); inc = 0; dec = 0; tick(2);
    #2 chk("simul_at_max", bpm_o, 300);
    dec = 1; tick(1); dec = 0; tick(2);
    #2 chk("dec_one", bpm_o, 299);
    inc = 1; dec = 1; tick(3); inc = 0; dec = 0; tick(2);
    #2 chk("simul_mid", bpm_o, 299);

    // Reset during a hold, then a short press gives exactly one step
    inc = 1; tick(30); rst = 1; tick(1); inc = 0; tick(2); rst = 0; tick(2);
    #2 chk("rst_hold_bpm", bpm_o, 120);
    inc = 1; tick(10); inc = 0; tick(2);
    #2 chk("idle_after_rst", bpm_o, 121);

    // Randomized buttons, run toggles and occasional reset
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) < 3) inc = ~inc;
      if ($urandom_range(0, 99) < 3) dec = ~dec;
      if ($urandom_range(0, 199) < 1) run = ~run;
      rst = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    inc = 0; dec = 0; run = 0; rst = 0; tick(5);
    #2 chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
